// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//   Sequences one FFT frame: a bit-reversal reorder pass followed by
//   N_LOG2 butterfly passes. Ownership of the shared dual-port sample RAM is
//   handed to whichever engine is running. When no engine is running, the RAM
//   goes back to the display reader.
//
//   Optional feature: define WATCHDOG_EN to add a per-wait-state timeout.
//   Without it, the wait states wait indefinitely and err_o is tied low.
//
// Ports
//   clk_i           system clock, rising edge
//   reset_n_i       asynchronous active-low reset
//   start_i         frame request, sampled only while idle
//   abort_i         synchronous abort back to idle from any state
//   bitrev_start_o  1-cycle kick to the bit-reversal unit
//   bitrev_tc_i     terminal count from the bit-reversal unit
//   bf_start_o      1-cycle kick to the butterfly engine
//   bf_stage_o      current butterfly pass index, 0..N_LOG2-1
//   bf_tc_i         terminal count from the butterfly engine
//   ram_owner_o     RAM mux select: 00 display, 01 bit-reversal, 10 butterfly
//   busy_o          high in every state except idle
//   done_o          1-cycle pulse when a frame completes
//   frame_cnt_o     completed-frame counter, wraps 255 -> 0
//   err_o           sticky watchdog error
module fft_frame_sequencer #(
    parameter int N_LOG2  = 10,
    parameter int STAGE_W = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               start_i,
    input  logic               abort_i,
    output logic               bitrev_start_o,
    input  logic               bitrev_tc_i,
    output logic               bf_start_o,
    output logic [STAGE_W-1:0] bf_stage_o,
    input  logic               bf_tc_i,
    output logic [1:0]         ram_owner_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [7:0]         frame_cnt_o,
    output logic               err_o
);

    localparam logic [STAGE_W-1:0] LAST_STAGE  = STAGE_W'(N_LOG2 - 1);
    localparam logic [1:0]         OWN_DISPLAY = 2'b00;
    localparam logic [1:0]         OWN_BITREV  = 2'b01;
    localparam logic [1:0]         OWN_BFLY    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BR_GO,
        S_BR_WAIT,
        S_BF_GO,
        S_BF_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;

    // Registered Moore outputs, decoded from the next state so that they
    // line up with the state they describe.
    logic               bitrev_start_q, bitrev_start_d;
    logic               bf_start_q, bf_start_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [1:0]         ram_owner_q, ram_owner_d;

`ifdef WATCHDOG_EN
    localparam int             WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic            err_q, err_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_expired;
`else
    // TIMEOUT only matters when the watchdog is built in.
    logic            unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        frame_cnt_d = frame_cnt_q;
`ifdef WATCHDOG_EN
        err_d       = err_q;
        wd_expired  = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = S_BR_GO;
`ifdef WATCHDOG_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_BR_GO: begin
                state_d = S_BR_WAIT;
            end
            S_BR_WAIT: begin
                if (bitrev_tc_i) begin
                    stage_d = '0;
                    state_d = S_BF_GO;
                end
            end
            S_BF_GO: begin
                state_d = S_BF_WAIT;
            end
            S_BF_WAIT: begin
                if (bf_tc_i) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d = S_DONE;
                    end else begin
                        stage_d = stage_q + 1'b1;
                        state_d = S_BF_GO;
                    end
                end
            end
            S_DONE: begin
                frame_cnt_d = frame_cnt_q + 8'd1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef WATCHDOG_EN
        // A terminal count arriving in the last allowed cycle still wins.
        wd_expired = (wd_q == WD_LAST) &&
                     (((state_q == S_BR_WAIT) && !bitrev_tc_i) ||
                      ((state_q == S_BF_WAIT) && !bf_tc_i));
        if (wd_expired) begin
            state_d = S_IDLE;
            stage_d = '0;
            err_d   = 1'b1;
        end
`endif

        // Abort overrides everything, including a same-cycle terminal count.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            stage_d     = '0;
            frame_cnt_d = frame_cnt_q;
`ifdef WATCHDOG_EN
            err_d       = err_q;
`endif
        end
    end

`ifdef WATCHDOG_EN
    // The counter runs only while the FSM stays in a wait state. Any state
    // change, including entry to a wait state, restarts it from zero.
    always_comb begin
        wd_d = '0;
        if ((state_d == state_q) &&
            ((state_q == S_BR_WAIT) || (state_q == S_BF_WAIT))) begin
            wd_d = wd_q + 1'b1;
        end
    end
`endif

    // Output decode
    always_comb begin
        bitrev_start_d = (state_d == S_BR_GO);
        bf_start_d     = (state_d == S_BF_GO);
        done_d         = (state_d == S_DONE);
        busy_d         = (state_d != S_IDLE);
        case (state_d)
            S_BR_GO, S_BR_WAIT: ram_owner_d = OWN_BITREV;
            S_BF_GO, S_BF_WAIT: ram_owner_d = OWN_BFLY;
            default:            ram_owner_d = OWN_DISPLAY;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= S_IDLE;
            stage_q        <= '0;
            frame_cnt_q    <= '0;
            bitrev_start_q <= 1'b0;
            bf_start_q     <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            ram_owner_q    <= OWN_DISPLAY;
        end else begin
            state_q        <= state_d;
            stage_q        <= stage_d;
            frame_cnt_q    <= frame_cnt_d;
            bitrev_start_q <= bitrev_start_d;
            bf_start_q     <= bf_start_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            ram_owner_q    <= ram_owner_d;
        end
    end

`ifdef WATCHDOG_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q <= 1'b0;
            wd_q  <= '0;
        end else begin
            err_q <= err_d;
            wd_q  <= wd_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign bitrev_start_o = bitrev_start_q;
    assign bf_start_o     = bf_start_q;
    assign bf_stage_o     = stage_q;
    assign ram_owner_o    = ram_owner_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign frame_cnt_o    = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
`timescale 1ns/1ps
module tb_fft_frame_sequencer;

    localparam int N_LOG2  = 10;
    localparam int STAGE_W = 4;
`ifdef WATCHDOG_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 4096;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic               start, abort;
    logic               stray_br, stray_bf;
    logic               resp_br, resp_bf;
    logic               bitrev_start_o, bf_start_o, busy_o, done_o, err_o;
    logic [STAGE_W-1:0] bf_stage_o;
    logic [1:0]         ram_owner_o;
    logic [7:0]         frame_cnt_o;

    fft_frame_sequencer #(
        .N_LOG2 (N_LOG2),
        .STAGE_W(STAGE_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .start_i       (start),
        .abort_i       (abort),
        .bitrev_start_o(bitrev_start_o),
        .bitrev_tc_i   (resp_br | stray_br),
        .bf_start_o    (bf_start_o),
        .bf_stage_o    (bf_stage_o),
        .bf_tc_i       (resp_bf | stray_bf),
        .ram_owner_o   (ram_owner_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .frame_cnt_o   (frame_cnt_o),
        .err_o         (err_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a frame is an ordered list of engine events.
    // kind 0 = bit-reversal kick, 1 = butterfly kick (with pass index), 2 = done.
    typedef struct {
        int kind;
        int stage;
    } ev_t;
    ev_t exp_q[$];
    int  exp_fc = 0;

    function automatic void push_frame(input int last_stage, input bit with_done);
        exp_q.push_back('{0, 0});
        for (int s = 0; s <= last_stage; s++) exp_q.push_back('{1, s});
        if (with_done) exp_q.push_back('{2, 0});
    endfunction

    // Monitor / scoreboard
    int done_seen = 0;
    int bf_seen   = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset_n) begin
                int   k;
                int   npulse;
                ev_t  e;
                npulse = int'(bitrev_start_o) + int'(bf_start_o) + int'(done_o);
                if (npulse > 1) begin
                    checks++;
                    failures++;
                    $display("FAIL pulse_overlap: got %0d simultaneous pulses expected 1", npulse);
                end else if (npulse == 1) begin
                    k = bitrev_start_o ? 0 : (bf_start_o ? 1 : 2);
                    if (k == 2) done_seen++;
                    if (k == 1) bf_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pulse: got kind %0d expected no pulse", k);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_kind", k, e.kind);
                        if (k == 1) check("bf_stage", bf_stage_o, e.stage);
                        check("ram_owner", ram_owner_o, (k == 0) ? 1 : ((k == 1) ? 2 : 0));
`ifndef WATCHDOG_EN
                        check("err_tied", err_o, 0);
`endif
                    end
                end
            end
        end
    end

    // Engine responders: terminal count a programmable number of cycles after each kick.
    int br_delay = 5;
    int bf_delay = 3;
    bit br_en    = 1'b1;
    int br_timer = 0;
    int bf_timer = 0;
    initial begin
        resp_br = 1'b0;
        resp_bf = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            resp_br = 1'b0;
            resp_bf = 1'b0;
            if (!reset_n || !busy_o) begin
                br_timer = 0;
                bf_timer = 0;
            end else begin
                if (bitrev_start_o) br_timer = br_en ? br_delay : 0;
                else if (br_timer > 0) begin
                    br_timer--;
                    if (br_timer == 0) resp_br = 1'b1;
                end
                if (bf_start_o) bf_timer = bf_delay;
                else if (bf_timer > 0) begin
                    bf_timer--;
                    if (bf_timer == 0) resp_bf = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_seen < target; i++) tick();
        check("done_within_budget", done_seen >= target, 1);
    endtask

    task automatic run_frame();
        int target;
        target = done_seen + 1;
        push_frame(N_LOG2 - 1, 1'b1);
        exp_fc++;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_latency", bitrev_start_o, 1);
        wait_done(target, 400);
        tick();
        check("frame_cnt", frame_cnt_o, exp_fc & 255);
        check("idle_busy", busy_o, 0);
        check("idle_owner", ram_owner_o, 0);
        check("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        int target;
        int fc_before;
        bit found;

        start    = 1'b0;
        abort    = 1'b0;
        stray_br = 1'b0;
        stray_bf = 1'b0;
        reset_n  = 1'b1;
        #1 reset_n = 1'b0;

        // 1: reset with random inputs
        for (int i = 0; i < 6; i++) begin
            start    = 1'($urandom_range(0, 1));
            abort    = 1'($urandom_range(0, 1));
            stray_br = 1'($urandom_range(0, 1));
            stray_bf = 1'($urandom_range(0, 1));
            tick();
            check("reset_outputs", {bitrev_start_o, bf_start_o, bf_stage_o, ram_owner_o,
                                    busy_o, done_o, frame_cnt_o, err_o}, 0);
        end
        start    = 1'b0;
        abort    = 1'b0;
        stray_br = 1'b0;
        stray_bf = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("post_reset_busy", busy_o, 0);

        // 2: full frame, fixed engine latencies
        br_delay = 5;
        bf_delay = 3;
        run_frame();

        // 3: stray bf_tc during bit-reversal, start pulses during butterfly passes
        br_delay = 8;
        target   = done_seen + 1;
        push_frame(N_LOG2 - 1, 1'b1);
        exp_fc++;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        stray_bf = 1'b1;
        tick();
        stray_bf = 1'b0;
        fc_before = bf_seen;
        for (int i = 0; i < 50 && bf_seen == fc_before; i++) tick();
        check("first_bf_seen", bf_seen > fc_before, 1);
        tick();
        start    = 1'b1;
        stray_br = 1'b1;
        tick();
        start    = 1'b0;
        stray_br = 1'b0;
        wait_done(target, 400);
        tick();
        check("frame_cnt_stray", frame_cnt_o, exp_fc & 255);
        check("sb_empty_stray", exp_q.size(), 0);

        // 4: abort coinciding with bf_tc at pass 4
        br_delay = 5;
        bf_delay = 3;
        fc_before = int'(frame_cnt_o);
        target = done_seen;
        push_frame(4, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (bf_start_o && bf_stage_o == 4'd4) found = 1'b1;
        end
        check("stage4_reached", found, 1);
        tick();
        tick();
        tick();
        check("abort_with_tc", resp_bf, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_done", done_o, 0);
        check("abort_stage", bf_stage_o, 0);
        check("abort_owner", ram_owner_o, 0);
        check("abort_frame_cnt", frame_cnt_o, fc_before);
        repeat (8) tick();
        check("abort_no_done", done_seen, target);
        check("sb_empty_abort", exp_q.size(), 0);

        // start together with abort in idle is refused
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", {busy_o, bitrev_start_o}, 0);
        tick();
        check("start_abort_idle2", busy_o, 0);
        run_frame();

        // reset in the middle of a frame
        push_frame(N_LOG2 - 1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        reset_n = 1'b0;
        #1;
        check("midframe_reset", {bitrev_start_o, bf_start_o, bf_stage_o, ram_owner_o,
                                 busy_o, done_o, frame_cnt_o, err_o}, 0);
        exp_q.delete();
        exp_fc = 0;
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        check("no_rearm_after_reset", busy_o, 0);

        // 5: 256 back-to-back frames with random engine latencies
        target = done_seen + 256;
        for (int f = 0; f < 256; f++) begin
            br_delay = $urandom_range(1, 6);
            bf_delay = $urandom_range(1, 4);
            run_frame();
        end
        check("wrap_frame_cnt", frame_cnt_o, 0);
        check("wrap_done_count", done_seen, target);

`ifdef WATCHDOG_EN
        // 6: watchdog on a silent bit-reversal unit
        br_en    = 1'b0;
        br_delay = 5;
        bf_delay = 3;
        exp_q.push_back('{0, 0});
        start = 1'b1;
        tick();
        start = 1'b0;
        check("wd_kick", bitrev_start_o, 1);
        repeat (16) tick();
        check("wd_still_waiting", busy_o, 1);
        check("wd_err_early", err_o, 0);
        tick();
        check("wd_busy", busy_o, 0);
        check("wd_err", err_o, 1);
        check("wd_frame_cnt", frame_cnt_o, exp_fc & 255);
        br_en  = 1'b1;
        target = done_seen + 1;
        push_frame(N_LOG2 - 1, 1'b1);
        exp_fc++;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("wd_err_cleared", err_o, 0);
        wait_done(target, 400);
        tick();
        check("wd_frame_after", frame_cnt_o, exp_fc & 255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
